// File: rtl/collision_event_generator_pkg.sv
// Shared types and flag-vector indices for the collision event generator.
package collision_pkg;

  // Player life state: normal, temporarily immune to missiles, or game over.
  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } coll_state_t;

  // Bit positions in the 4-bit overlap/flag/pulse vectors.
  localparam int COLL_MISSILE = 0;  // player vs monster missile
  localparam int COLL_MONSTER = 1;  // player vs monster
  localparam int COLL_KILL    = 2;  // player missile vs monster
  localparam int COLL_SHIELD  = 3;  // monster vs shield
  localparam int COLL_NUM     = 4;

endpackage

// File: rtl/collision_event_generator_if.sv
// Drawing-request inputs and collision/status outputs of the collision event generator.
interface collision_event_generator_if;
  logic startOfFrame;
  logic playerDR;
  logic monsterDR;
  logic monsterMissileDR;
  logic shieldDR;
  logic playerMissileDR;
  logic collision0;
  logic collision1;
  logic collision2;
  logic collision3;
  logic invulnerable;
  logic playerVisible;
  logic gameOver;

  // Video/sprite side: drives frame timing and drawing requests, receives events.
  modport master (
    output startOfFrame, playerDR, monsterDR, monsterMissileDR, shieldDR, playerMissileDR,
    input  collision0, collision1, collision2, collision3, invulnerable, playerVisible, gameOver
  );

  // Event generator side.
  modport slave (
    input  startOfFrame, playerDR, monsterDR, monsterMissileDR, shieldDR, playerMissileDR,
    output collision0, collision1, collision2, collision3, invulnerable, playerVisible, gameOver
  );
endinterface

// File: rtl/collision_event_generator_sticky_frame_flag.sv
// One per-frame sticky overlap flag: set by its term, cleared at frame start,
// with a term on the frame-start cycle counting towards the new frame.
module sticky_frame_flag (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic set,
  input  logic enable,
  output logic flag
);

  logic flag_reg, flag_next;

  // Clear on frame start first, then let an enabled set override it.
  always_comb begin
    flag_next = flag_reg;
    if (sof) flag_next = 1'b0;
    if (set && enable) flag_next = 1'b1;
  end

  // Flag storage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) flag_reg <= 1'b0;
    else         flag_reg <= flag_next;
  end

  assign flag = flag_reg;

endmodule

// File: rtl/collision_event_generator.sv
// Collision event generator: latches sprite overlaps per frame, emits one pulse
// per event type after each frame start, and tracks invulnerability / game over.
module collision_event_generator
  import collision_pkg::*;
#(
  parameter int INVULN_FRAMES = 30,
  parameter int FLASH_PERIOD  = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  collision_event_generator_if.slave bus
);

  localparam int FCW = $clog2(INVULN_FRAMES + 1);
  localparam int LCW = $clog2(FLASH_PERIOD + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(INVULN_FRAMES - 1);
  localparam logic [LCW-1:0] FLASH_LAST = LCW'(FLASH_PERIOD - 1);

  coll_state_t         state_reg, state_next;
  logic [FCW-1:0]      frame_cnt_reg, frame_cnt_next;
  logic [LCW-1:0]      flash_cnt_reg, flash_cnt_next;
  logic                visible_reg, visible_next;
  logic [COLL_NUM-1:0] pulse_reg, pulse_next;
  logic [COLL_NUM-1:0] term;
  logic [COLL_NUM-1:0] enable;
  logic [COLL_NUM-1:0] flag;
  logic                fatal;

  // Per-pixel overlap terms.
  always_comb begin
    term               = '0;
    term[COLL_MISSILE] = bus.playerDR & bus.monsterMissileDR;
    term[COLL_MONSTER] = bus.playerDR & bus.monsterDR;
    term[COLL_KILL]    = bus.playerMissileDR & bus.monsterDR;
    term[COLL_SHIELD]  = bus.monsterDR & bus.shieldDR;
  end

  // Missile hits only count while armed; nothing is latched once dead.
  always_comb begin
    enable               = {COLL_NUM{state_reg != DEAD}};
    enable[COLL_MISSILE] = (state_reg == ARMED);
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLL_NUM; gi++) begin : g_flag
      sticky_frame_flag u_flag (
        .clk    (clk),
        .resetN (resetN),
        .sof    (bus.startOfFrame),
        .set    (term[gi]),
        .enable (enable[gi]),
        .flag   (flag[gi])
      );
    end
  endgenerate

  assign fatal = flag[COLL_MONSTER] | flag[COLL_SHIELD];

  // Frame-start evaluation: pulses, state transitions and invulnerability counters.
  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    flash_cnt_next = flash_cnt_reg;
    visible_next   = visible_reg;
    pulse_next     = '0;
    if (bus.startOfFrame && state_reg != DEAD) begin
      pulse_next[COLL_MONSTER] = flag[COLL_MONSTER];
      pulse_next[COLL_KILL]    = flag[COLL_KILL];
      pulse_next[COLL_SHIELD]  = flag[COLL_SHIELD];
      pulse_next[COLL_MISSILE] = (state_reg == ARMED) & flag[COLL_MISSILE] & ~flag[COLL_MONSTER];
      unique case (state_reg)
        ARMED: begin
          if (fatal) begin
            state_next = DEAD;
          end else if (flag[COLL_MISSILE]) begin
            state_next     = INVULN;
            frame_cnt_next = '0;
            flash_cnt_next = '0;
            visible_next   = 1'b0;
          end
        end
        INVULN: begin
          if (fatal) begin
            state_next   = DEAD;
            visible_next = 1'b1;
          end else if (frame_cnt_reg == FRAME_LAST) begin
            state_next   = ARMED;
            visible_next = 1'b1;
          end else begin
            frame_cnt_next = frame_cnt_reg + FCW'(1);
            if (flash_cnt_reg == FLASH_LAST) begin
              flash_cnt_next = '0;
              visible_next   = ~visible_reg;
            end else begin
              flash_cnt_next = flash_cnt_reg + LCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= ARMED;
      frame_cnt_reg <= '0;
      flash_cnt_reg <= '0;
      visible_reg   <= 1'b1;
      pulse_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      flash_cnt_reg <= flash_cnt_next;
      visible_reg   <= visible_next;
      pulse_reg     <= pulse_next;
    end
  end

  assign bus.collision0    = pulse_reg[COLL_MISSILE];
  assign bus.collision1    = pulse_reg[COLL_MONSTER];
  assign bus.collision2    = pulse_reg[COLL_KILL];
  assign bus.collision3    = pulse_reg[COLL_SHIELD];
  assign bus.invulnerable  = (state_reg == INVULN);
  assign bus.gameOver      = (state_reg == DEAD);
  assign bus.playerVisible = visible_reg;

endmodule

// File: tb/tb_collision_event_generator.sv
// Directed bench: dut_a (INVULN_FRAMES=3) and dut_b (INVULN_FRAMES=5) share stimulus.
module tb_collision_event_generator;

  logic clk;
  logic resetN;
  logic sof, pdr, mdr, mmdr, sdr, pmdr;
  int   errors;
  int   checks;

  collision_event_generator_if bus_a ();
  collision_event_generator_if bus_b ();

  assign bus_a.startOfFrame     = sof;
  assign bus_a.playerDR         = pdr;
  assign bus_a.monsterDR        = mdr;
  assign bus_a.monsterMissileDR = mmdr;
  assign bus_a.shieldDR         = sdr;
  assign bus_a.playerMissileDR  = pmdr;
  assign bus_b.startOfFrame     = sof;
  assign bus_b.playerDR         = pdr;
  assign bus_b.monsterDR        = mdr;
  assign bus_b.monsterMissileDR = mmdr;
  assign bus_b.shieldDR         = sdr;
  assign bus_b.playerMissileDR  = pmdr;

  collision_event_generator #(.INVULN_FRAMES(3), .FLASH_PERIOD(2)) dut_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_a)
  );

  collision_event_generator #(.INVULN_FRAMES(5), .FLASH_PERIOD(2)) dut_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_b)
  );

  logic [3:0] coll_a, coll_b;
  assign coll_a = {bus_a.collision3, bus_a.collision2, bus_a.collision1, bus_a.collision0};
  assign coll_b = {bus_b.collision3, bus_b.collision2, bus_b.collision1, bus_b.collision0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic sof_cycle();
    sof = 1'b1;
    cyc();
    sof = 1'b0;
  endtask

  task automatic clear_dr();
    pdr = 1'b0; mdr = 1'b0; mmdr = 1'b0; sdr = 1'b0; pmdr = 1'b0;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Expected per-frame values for the five evaluations after the first hit.
  logic [4:0] exp_c0_a  = 5'b01000;  // index k-1, k=1..5
  logic [4:0] exp_inv_a = 5'b11011;
  logic [4:0] exp_vis_a = 5'b00110;
  logic [4:0] exp_inv_b = 5'b01111;
  logic [4:0] exp_vis_b = 5'b10110;

  initial begin
    errors = 0;
    checks = 0;
    resetN = 1'b0;
    sof    = 1'b0;
    clear_dr();
    idle(3);

    // Reset values
    chk4("reset_coll", coll_a, 4'b0000);
    chk1("reset_inv", bus_a.invulnerable, 1'b0);
    chk1("reset_vis", bus_a.playerVisible, 1'b1);
    chk1("reset_gameover", bus_a.gameOver, 1'b0);
    resetN = 1'b1;
    idle(2);
    sof_cycle();
    chk4("first_sof_no_pulse", coll_a, 4'b0000);

    // Test 1: f0 for 3 cycles mid-frame -> one collision0 after next SOF
    idle(3);
    pdr = 1'b1; mmdr = 1'b1;
    idle(3);
    clear_dr();
    idle(2);
    chk4("t1_mid_frame_quiet", coll_a, 4'b0000);
    sof_cycle();
    chk4("t1_pulse_a", coll_a, 4'b0001);
    chk4("t1_pulse_b", coll_b, 4'b0001);
    chk1("t1_invulnerable", bus_a.invulnerable, 1'b1);
    chk1("t1_vis_entry_b", bus_b.playerVisible, 1'b0);
    cyc();
    chk4("t1_pulse_one_cycle", coll_a, 4'b0000);

    // Tests 2 and 5: f0 every frame; dut_a re-arms after 3 SOFs, dut_b flashes
    for (int k = 1; k <= 5; k++) begin
      idle(2);
      pdr = 1'b1; mmdr = 1'b1;
      cyc();
      clear_dr();
      idle(2);
      sof_cycle();
      chk1($sformatf("t2_c0_a_k%0d", k), bus_a.collision0, exp_c0_a[k-1]);
      chk1($sformatf("t2_inv_a_k%0d", k), bus_a.invulnerable, exp_inv_a[k-1]);
      chk1($sformatf("t2_vis_a_k%0d", k), bus_a.playerVisible, exp_vis_a[k-1]);
      chk1($sformatf("t5_c0_b_k%0d", k), bus_b.collision0, 1'b0);
      chk1($sformatf("t5_inv_b_k%0d", k), bus_b.invulnerable, exp_inv_b[k-1]);
      chk1($sformatf("t5_vis_b_k%0d", k), bus_b.playerVisible, exp_vis_b[k-1]);
    end

    // Test 6: dut_a in INVULN latches F1, reset mid-frame wipes it
    chk1("t6_pre_inv_a", bus_a.invulnerable, 1'b1);
    idle(2);
    pdr = 1'b1; mdr = 1'b1;
    cyc();
    clear_dr();
    idle(1);
    resetN = 1'b0;
    idle(2);
    chk4("t6_reset_coll", coll_a, 4'b0000);
    chk1("t6_reset_inv", bus_a.invulnerable, 1'b0);
    chk1("t6_reset_vis", bus_a.playerVisible, 1'b1);
    chk1("t6_reset_gameover", bus_a.gameOver, 1'b0);
    resetN = 1'b1;
    idle(2);
    sof_cycle();
    chk4("t6_no_c1_first_sof", coll_a, 4'b0000);
    idle(4);
    sof_cycle();
    chk4("t6_no_c1_second_sof", coll_a, 4'b0000);
    chk1("t6_not_dead", bus_a.gameOver, 1'b0);

    // Test 3: f0 and f1 in the same frame -> collision1 only, then dead
    idle(2);
    pdr = 1'b1; mmdr = 1'b1; mdr = 1'b1;
    cyc();
    clear_dr();
    idle(2);
    sof_cycle();
    chk4("t3_c1_only", coll_a, 4'b0010);
    chk1("t3_gameover", bus_a.gameOver, 1'b1);
    chk1("t3_not_inv", bus_a.invulnerable, 1'b0);
    chk1("t3_vis_dead", bus_a.playerVisible, 1'b1);
    cyc();
    chk4("t3_pulse_one_cycle", coll_a, 4'b0000);
    pdr = 1'b1; mdr = 1'b1; mmdr = 1'b1; sdr = 1'b1; pmdr = 1'b1;
    idle(3);
    clear_dr();
    sof_cycle();
    chk4("t3_dead_no_pulse", coll_a, 4'b0000);
    chk1("t3_still_dead", bus_a.gameOver, 1'b1);

    // Test 4: f2 and f3 only on an SOF cycle -> pulse after the following SOF
    resetN = 1'b0;
    idle(2);
    resetN = 1'b1;
    idle(2);
    sof_cycle();
    chk4("t4_clean_sof", coll_a, 4'b0000);
    idle(3);
    pmdr = 1'b1; mdr = 1'b1; sdr = 1'b1;
    sof_cycle();
    clear_dr();
    chk4("t4_no_pulse_this_sof", coll_a, 4'b0000);
    idle(3);
    sof_cycle();
    chk4("t4_c2_c3_pulse", coll_a, 4'b1100);
    chk1("t4_shield_fatal", bus_a.gameOver, 1'b1);
    cyc();
    chk4("t4_pulse_one_cycle", coll_a, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
